// File: rtl/ddr3_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_port_arbiter
// Brief    : Two-port round-robin arbiter between the core's instruction-fetch
//            port (read-only) and data port (read/write) in front of the
//            single DDR3 request FSM. One outstanding transaction at a time;
//            each response is routed back to the port that issued it.
// Options  : ARB_TIMEOUT_EN - when defined, a WAIT-state cycle counter aborts
//            a transaction after TIMEOUT_CYCLES with an err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_port_arbiter #(
  parameter int ADDR_W         = 29,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_sel,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_sel,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // DDR3 request FSM side
  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_bit32_select,
  input  logic              mem_read_data_valid,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_write_done,
  // status
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // owner / last-grant encoding
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel_q, sel_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic              w_pick;
  logic              w_done;
  logic              w_timeout;

  // Only the completion matching the latched direction counts.
  assign w_done = we_q ? mem_write_done : mem_read_data_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  // WAIT-cycle counter: held at zero outside WAIT so every entry starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      cnt_q <= '0;
    end else if (!w_done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign w_timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and output-pulse logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    rd_req_d   = 1'b0;
    wr_req_d   = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = 1'b0;
    w_pick     = OWN_I;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that did not win last time goes first.
          if (i_req && d_req) begin
            w_pick = (last_gnt_q == OWN_I) ? OWN_D : OWN_I;
          end else begin
            w_pick = d_req ? OWN_D : OWN_I;
          end
          owner_d = w_pick;
          if (w_pick == OWN_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            sel_d   = d_sel;
            d_gnt_d = 1'b1;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            sel_d   = i_sel;
            i_gnt_d = 1'b1;
          end
          rd_req_d = !((w_pick == OWN_D) && d_we);
          wr_req_d =  ((w_pick == OWN_D) && d_we);
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        last_gnt_d = owner_q;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (w_done) begin
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_read_data;
            end
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = mem_read_data;
          end
          state_d = S_RESP;
        end else if (w_timeout) begin
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = '0;
          end
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      default: begin
        // RESP: one-cycle gap before requests are sampled again.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_I;
      last_gnt_q <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign i_gnt            = i_gnt_q;
  assign d_gnt            = d_gnt_q;
  assign i_rvalid         = i_rvalid_q;
  assign d_rvalid         = d_rvalid_q;
  assign i_rdata          = i_rdata_q;
  assign d_rdata          = d_rdata_q;
  assign mem_read_req     = rd_req_q;
  assign mem_write_req    = wr_req_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign mem_bit32_select = sel_q;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;

endmodule
`default_nettype wire

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Two-port round-robin arbiter that shares the single DDR3 request FSM between the RISC-V core's instruction fetch port (read-only) and data port (read/write). It sits between the core's memory ports and the DDR3 controller FSM. It serialises accesses: one outstanding transaction at a time. It routes each response back to the port that issued it.

## Interface
- ADDR_W, 29, DDR3 application address width
- DATA_W, 32, word width of both ports
- TIMEOUT_CYCLES, 1023, maximum WAIT cycles before abort (used only with timeout feature)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request, held until i_gnt
- i_addr  in  ADDR_W  instruction address
- i_sel  in  1  32-bit half select (1 = upper)
- i_gnt  out  1  one-cycle accept pulse; payload latched
- i_rvalid  out  1  one-cycle response pulse
- i_rdata  out  DATA_W  read data, valid with i_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_sel  in  1  32-bit half select
- d_gnt  out  1  one-cycle accept pulse
- d_rvalid  out  1  one-cycle completion pulse (read data or write ack)
- d_rdata  out  DATA_W  read data, valid with d_rvalid on reads
- mem_read_req / mem_write_req  out  1  one-cycle request pulses to DDR3 FSM
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_bit32_select  out  1  latched half select
- mem_read_data_valid  in  1  read completion from DDR3 FSM
- mem_read_data  in  DATA_W  read data from DDR3 FSM
- mem_write_done  in  1  write completion from DDR3 FSM
- busy  out  1  high in any state other than IDLE
- err  out  1  timeout abort pulse, coincident with x_rvalid

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample i_req and d_req.
  - One request: grant it.
  - Both requests: grant the port not granted last (last_gnt register).
  - On grant: latch owner, we (forced 0 for the I port), addr, wdata, sel. Go to ISSUE.
- ISSUE: the owner's x_gnt is 1 and exactly one of mem_read_req/mem_write_req is 1, both for this cycle only. Update last_gnt to the owner. Go to WAIT.
- WAIT: a read completes on mem_read_data_valid; a write completes on mem_write_done.
  - Capture mem_read_data into the owner's x_rdata.
  - Go to RESP with the owner's x_rvalid = 1.
  - The completion signal of the other type is ignored.
- RESP: one-cycle gap, then IDLE. Requests are not sampled in ISSUE, WAIT or RESP.
- Write completion: d_rvalid pulses and d_rdata keeps its previous value.
- Requesters deassert x_req the cycle after seeing x_gnt. A req still high in IDLE after RESP is treated as a new request.
- Reset values: every output 0, state IDLE, last_gnt = I so the first tie goes to the D port. Reset mid-transaction drops the transaction and emits no response.

## Timing
- Request sampled high in IDLE at edge N → at edge N+1, x_gnt and mem_*_req go high (registered, coincident).
- Completion input high in cycle M → at edge M+1, x_rvalid and x_rdata are set.
- At edge M+2, state is IDLE. The earliest next grant is at edge M+3.
- Minimum transaction: 4 cycles from request to IDLE.
- mem_addr, mem_wdata and mem_bit32_select are stable from ISSUE through RESP.
- Completion arriving in the same cycle as ISSUE is ignored; only WAIT samples completions.

## Configuration
- ARB_TIMEOUT_EN defined:
  - WAIT runs a cycle counter cleared on entry (width clog2(TIMEOUT_CYCLES+1)).
  - When the counter reaches TIMEOUT_CYCLES with no completion, go to RESP with x_rvalid = 1, err = 1 and x_rdata = 0.
  - A completion in the same cycle as the timeout wins: normal response, err = 0.
- ARB_TIMEOUT_EN undefined: no counter, WAIT holds indefinitely, err tied 0.

## Test plan
- Single I read: i_req, i_addr=0x100, i_sel=0; mem_read_data=0xDEADBEEF 5 cycles after mem_read_req → i_gnt at N+1, mem_read_req 1 cycle, i_rvalid with 0xDEADBEEF, d_* outputs stay 0.
- D write: d_we=1, d_addr=0x200, d_wdata=0x12345678, d_sel=1 → mem_write_req pulse, mem_wdata=0x12345678, mem_bit32_select=1. mem_write_done → d_rvalid pulse, d_rdata unchanged.
- Simultaneous requests from reset, held for 3 transactions → grant order D, I, D; exactly one mem request pulse per transaction.
- Stray mem_write_done during a read WAIT → ignored; response only on mem_read_data_valid, with the correct data.
- rst_n low during WAIT, then a late mem_read_data_valid → no i_rvalid or d_rvalid, all outputs 0, next request is granted normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no completion → d_rvalid and err at edge 9 after WAIT entry, d_rdata=0. Without the macro, busy stays 1.
